axi4_pxl_write_master: RTL and testbench
========================================

# axi4_pxl_write_master

Downstream neighbour of the grayscale downscaler. It accepts downscaled pixels over a valid/ready handshake and packs `DATA_W/GS_PXL_W` pixels into each AXI4 write beat. It issues fixed-length INCR bursts into a frame buffer at `FRAME_BASE` and retires write responses, wrapping the address at every frame. It drives the downscaler's AW-ready and W-ready inputs, which gate every pixel transfer.

## Interface
- GS_PXL_W, 8, pixel width
- DATA_W, 32, AXI data width; PPB = DATA_W/GS_PXL_W pixels per beat
- ADDR_W, 32, AXI address width
- COL_NUM, 320, downscaled columns per frame
- ROW_NUM, 240, downscaled rows per frame
- BURST_LEN, 16, beats per burst; COL_NUM*ROW_NUM must be divisible by PPB*BURST_LEN
- OUTSTD_MAX, 4, maximum bursts with AW accepted and B not yet received
- FRAME_BASE, 32'h0000_0000, byte address of pixel 0; aligned to BURST_LEN*DATA_W/8
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ds_pxl_i  in  GS_PXL_W  downscaled pixel
- ds_pxl_vld_i  in  1  pixel valid
- ds_aw_rdy_o  out  1  pixel's burst has its AW accepted
- ds_w_rdy_o  out  1  beat buffer can absorb pixel
- m_awaddr_o  out  ADDR_W  burst address
- m_awlen_o  out  8  BURST_LEN-1
- m_awsize_o  out  3  log2(DATA_W/8)
- m_awburst_o  out  2  2'b01 (INCR)
- m_awvalid_o  out  1  AW valid
- m_awready_i  in  1  AW ready
- m_wdata_o  out  DATA_W  packed pixels
- m_wstrb_o  out  DATA_W/8  all ones
- m_wlast_o  out  1  last beat of burst
- m_wvalid_o  out  1  W valid
- m_wready_i  in  1  W ready
- m_bresp_i  in  2  write response
- m_bvalid_i  in  1  B valid
- m_bready_o  out  1  B ready, constant 1 outside reset
- frame_done_o  out  1  one-cycle pulse on the last B of a frame
- wr_err_o  out  1  sticky, set on any bresp != 2'b00

## Operation
- Pixel handshake: pxl_hsk = ds_pxl_vld_i & ds_aw_rdy_o & ds_w_rdy_o.
- Packer: holds PPB-1 partial pixels. Pixel k of a beat goes to bits [k*GS_PXL_W +: GS_PXL_W], first pixel in the LSB.
- On the PPB-th pixel, the full word is pushed into a 2-entry beat FIFO. ds_w_rdy_o = (fifo count < 2).
- W channel: m_wvalid_o = FIFO non-empty; m_wdata_o = FIFO head; pop on m_wvalid_o & m_wready_i.
- Beat counter 0..BURST_LEN-1 advances on each W handshake. m_wlast_o = (beat counter == BURST_LEN-1).
- AW FSM has two states:
  - AW_IDLE: go to AW_SEND when outstanding < OUTSTD_MAX.
  - AW_SEND: hold m_awvalid_o=1 with a stable address. On m_awready_i, advance the burst index and return to AW_IDLE.
- AW address: m_awaddr_o = FRAME_BASE + burst_idx*BURST_LEN*DATA_W/8. burst_idx wraps to 0 after COL_NUM*ROW_NUM/(PPB*BURST_LEN)-1.
- aw_credit counter:
  - +1 on AW handshake.
  - -1 on the pxl_hsk that accepts pixel BURST_LEN*PPB-1 of a burst.
  - Simultaneous +1/-1 leaves it unchanged.
  - ds_aw_rdy_o = (aw_credit != 0).
- outstanding counter: +1 on AW handshake, -1 on B handshake; simultaneous events net to zero. Range 0..OUTSTD_MAX.
- B channel:
  - Count B handshakes modulo bursts-per-frame.
  - frame_done_o pulses on the B handshake that completes the frame.
  - wr_err_o is set on an error response and cleared only by rst.
- Reset:
  - All outputs 0 except the constant AW fields, which are driven to their fixed values.
  - All counters, FIFO and FSM cleared, including mid-burst.
  - Partial beats are discarded; the next frame starts at FRAME_BASE.

## Timing
- AW: m_awvalid_o rises the first cycle after rst deasserts (AW_IDLE→AW_SEND registered). It drops the cycle after the handshake and may rise again one cycle later.
- Pixel to beat: PPB-th pixel accepted at cycle N → m_wvalid_o=1 at N+1 with that word.
- Throughput: one pixel per cycle sustained while m_wready_i=1 and AW credit is available.
- ds_w_rdy_o and ds_aw_rdy_o are registered-state decodes; there is no combinational path from m_*ready_i to them.
- frame_done_o is registered, asserted the cycle after the final B handshake.

## Test plan
Small configuration: COL_NUM=8, ROW_NUM=4, BURST_LEN=2, OUTSTD_MAX=2, PPB=4 (4 bursts/frame, 32 bytes).
- Reset/idle: hold rst 3 cycles, AXI slave always ready → after rst, m_awaddr_o=0x00 then 0x08; outstanding stalls at 2 with no B returned; ds_aw_rdy_o=1.
- Packing: pixels 0x01..0x08 with all ready → beats 0x04030201 then 0x08070605; m_wlast_o=1 on the second beat; m_wstrb_o=4'hF.
- W backpressure: m_wready_i=0 for 20 cycles while pixels are offered → ds_w_rdy_o=0 after 2 beats are buffered; no pixel lost or duplicated after release.
- AW starvation: m_awready_i=0 → ds_aw_rdy_o=0 and no pixel accepted. Release → addresses 0x00, 0x08, 0x10, 0x18, then wrap to 0x00.
- Frame/B: full frame with bresp=OKAY except the third B = 2'b10 → wr_err_o set from that B on; frame_done_o one pulse after the fourth B.
- Mid-burst reset: assert rst after 5 pixels → all valids 0 next cycle; the following frame's first AW is 0x00 and its first beat holds the new pixels only.

Source files
------------

// File: rtl/axi4_pxl_write_master.sv
// Packs downscaled grayscale pixels into AXI4 write beats and writes them as fixed-length
// INCR bursts into a frame buffer that wraps every frame, retiring write responses.
module axi4_pxl_write_master #(
    parameter int unsigned       GS_PXL_W   = 8,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       COL_NUM    = 320,
    parameter int unsigned       ROW_NUM    = 240,
    parameter int unsigned       BURST_LEN  = 16,
    parameter int unsigned       OUTSTD_MAX = 4,
    parameter logic [ADDR_W-1:0] FRAME_BASE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GS_PXL_W-1:0]   ds_pxl_i,
    input  logic                  ds_pxl_vld_i,
    output logic                  ds_aw_rdy_o,
    output logic                  ds_w_rdy_o,
    output logic [ADDR_W-1:0]     m_awaddr_o,
    output logic [7:0]            m_awlen_o,
    output logic [2:0]            m_awsize_o,
    output logic [1:0]            m_awburst_o,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    output logic                  m_wlast_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    input  logic [1:0]            m_bresp_i,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,
    output logic                  frame_done_o,
    output logic                  wr_err_o
);

    localparam int unsigned PPB         = DATA_W / GS_PXL_W;
    localparam int unsigned PPBURST     = PPB * BURST_LEN;
    localparam int unsigned BPF         = (COL_NUM * ROW_NUM) / PPBURST;
    localparam int unsigned BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int unsigned SLOT_W      = $clog2(PPB + 1);
    localparam int unsigned PCNT_W      = $clog2(PPBURST + 1);
    localparam int unsigned BEAT_W      = $clog2(BURST_LEN + 1);
    localparam int unsigned BIDX_W      = $clog2(BPF + 1);
    localparam int unsigned OUT_W       = $clog2(OUTSTD_MAX + 1);

    typedef enum logic {AW_IDLE, AW_SEND} aw_state_e;

    aw_state_e             aw_state_q;
    logic [BIDX_W-1:0]     burst_idx_q;
    logic [ADDR_W-1:0]     awaddr_q;

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [DATA_W-1:0]     pack_q, pack_d;
    logic [DATA_W-1:0]     fifo_q [2];
    logic [DATA_W-1:0]     fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            fcnt_q, fcnt_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [OUT_W-1:0]      credit_q, credit_d, outstd_q, outstd_d;
    logic [BIDX_W-1:0]     bcnt_q, bcnt_d;
    logic                  frame_done_q, frame_done_d, wr_err_q, wr_err_d;
    logic                  run_q;

    logic                  pxl_hsk, aw_hsk, w_hsk, b_hsk, push, burst_end;
    logic [DATA_W-1:0]     full_word;

    assign m_awlen_o    = 8'(BURST_LEN - 1);
    assign m_awsize_o   = 3'($clog2(DATA_W / 8));
    assign m_awburst_o  = 2'b01;
    assign m_awaddr_o   = awaddr_q;
    assign m_awvalid_o  = (aw_state_q == AW_SEND);

    assign m_wvalid_o   = (fcnt_q != 2'd0);
    assign m_wdata_o    = fifo_q[rd_ptr_q];
    assign m_wstrb_o    = {(DATA_W/8){run_q}};
    assign m_wlast_o    = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign m_bready_o   = run_q;
    assign frame_done_o = frame_done_q;
    assign wr_err_o     = wr_err_q;

    // Both readies decode registered state only, so slave readies never reach the upstream.
    assign ds_w_rdy_o   = run_q & (fcnt_q != 2'd2);
    assign ds_aw_rdy_o  = (credit_q != '0);

    assign pxl_hsk   = ds_pxl_vld_i & ds_aw_rdy_o & ds_w_rdy_o;
    assign aw_hsk    = m_awvalid_o & m_awready_i;
    assign w_hsk     = m_wvalid_o & m_wready_i;
    assign b_hsk     = m_bvalid_i & m_bready_o;
    assign push      = pxl_hsk & (slot_q == SLOT_W'(PPB - 1));
    assign burst_end = pxl_hsk & (pcnt_q == PCNT_W'(PPBURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_state_q  <= AW_IDLE;
            burst_idx_q <= '0;
            awaddr_q    <= '0;
        end else begin
            case (aw_state_q)
                AW_IDLE: if (outstd_q < OUT_W'(OUTSTD_MAX)) begin
                    aw_state_q <= AW_SEND;
                    awaddr_q   <= FRAME_BASE + ADDR_W'(burst_idx_q) * ADDR_W'(BURST_BYTES);
                end
                AW_SEND: if (m_awready_i) begin
                    aw_state_q  <= AW_IDLE;
                    burst_idx_q <= (burst_idx_q == BIDX_W'(BPF - 1)) ? '0
                                                                     : burst_idx_q + BIDX_W'(1);
                end
                default: aw_state_q <= AW_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can leave it unassigned
        // and infer a latch.
        full_word = pack_q;
        full_word[slot_q*GS_PXL_W +: GS_PXL_W] = ds_pxl_i;
        slot_d   = slot_q;
        pcnt_d   = pcnt_q;
        pack_d   = pack_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        beat_d   = beat_q;
        credit_d = credit_q;
        outstd_d = outstd_q;
        bcnt_d   = bcnt_q;
        wr_err_d = wr_err_q;
        frame_done_d = 1'b0;

        if (pxl_hsk) begin
            pack_d = full_word;
            slot_d = push ? '0 : slot_q + SLOT_W'(1);
            pcnt_d = burst_end ? '0 : pcnt_q + PCNT_W'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = full_word;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_hsk) begin
            rd_ptr_d = ~rd_ptr_q;
            beat_d   = (beat_q == BEAT_W'(BURST_LEN - 1)) ? '0 : beat_q + BEAT_W'(1);
        end
        if (push && !w_hsk)      fcnt_d = fcnt_q + 2'd1;
        else if (!push && w_hsk) fcnt_d = fcnt_q - 2'd1;

        if (aw_hsk && !burst_end)      credit_d = credit_q + OUT_W'(1);
        else if (!aw_hsk && burst_end) credit_d = credit_q - OUT_W'(1);

        if (aw_hsk && !b_hsk)      outstd_d = outstd_q + OUT_W'(1);
        else if (!aw_hsk && b_hsk) outstd_d = outstd_q - OUT_W'(1);

        if (b_hsk) begin
            frame_done_d = (bcnt_q == BIDX_W'(BPF - 1));
            bcnt_d       = frame_done_d ? '0 : bcnt_q + BIDX_W'(1);
            if (m_bresp_i != 2'b00) wr_err_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            pcnt_q       <= '0;
            pack_q       <= '0;
            // NOTE: the beat registers are reset as well so m_wdata_o reads 0 during reset.
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fcnt_q       <= '0;
            beat_q       <= '0;
            credit_q     <= '0;
            outstd_q     <= '0;
            bcnt_q       <= '0;
            frame_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            pcnt_q       <= pcnt_d;
            pack_q       <= pack_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fcnt_q       <= fcnt_d;
            beat_q       <= beat_d;
            credit_q     <= credit_d;
            outstd_q     <= outstd_d;
            bcnt_q       <= bcnt_d;
            frame_done_q <= frame_done_d;
            wr_err_q     <= wr_err_d;
            run_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_pxl_write_master.sv
// Randomised bench for axi4_pxl_write_master in the small 8x4 / 2-beat-burst configuration,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_axi4_pxl_write_master;

    localparam int PIX_PER_BURST = 8;
    localparam int BPF           = 4;
    localparam int BURST_BYTES   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ds_pxl_i = '0;
    logic        ds_pxl_vld_i = 1'b0;
    logic        ds_aw_rdy_o, ds_w_rdy_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic [2:0]  m_awsize_o;
    logic [1:0]  m_awburst_o;
    logic        m_awvalid_o;
    logic        m_awready_i = 1'b0;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wlast_o, m_wvalid_o;
    logic        m_wready_i = 1'b0;
    logic [1:0]  m_bresp_i = '0;
    logic        m_bvalid_i = 1'b0;
    logic        m_bready_o, frame_done_o, wr_err_o;

    axi4_pxl_write_master #(
        .GS_PXL_W(8), .DATA_W(32), .ADDR_W(32), .COL_NUM(8), .ROW_NUM(4),
        .BURST_LEN(2), .OUTSTD_MAX(2), .FRAME_BASE(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .ds_pxl_i(ds_pxl_i), .ds_pxl_vld_i(ds_pxl_vld_i),
        .ds_aw_rdy_o(ds_aw_rdy_o), .ds_w_rdy_o(ds_w_rdy_o),
        .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
        .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .frame_done_o(frame_done_o), .wr_err_o(wr_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs, written by the test sequence
    int         vld_pct = 0, awr_pct = 0, wr_pct = 0, b_pct = 0;
    int         pix_budget = 0;
    int         err_b_idx = -1;
    logic [7:0] next_pix = '0;

    // Transaction-level model state: counts since the last reset
    bit          started = 0;
    bit          run_m = 0;
    int          aw_n = 0, b_n = 0, pix_n = 0, pop_n = 0, fd_count = 0;
    logic [7:0]  part[$];
    logic [31:0] word_q[$];
    bit          exp_awv = 0, exp_aw_rdy = 0, exp_w_rdy = 0, exp_wvalid = 0, exp_fd = 0, exp_err = 0;
    bit          aw_h, w_h, b_h, p_h, n_awv, pxl_taken = 0;
    int          outstd_before;
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    bit          wl_log[$];

    // Compare process: check this cycle, then advance the model across the coming edge
    always @(negedge clk) begin
        if (started) begin
            check("awvalid", m_awvalid_o, exp_awv);
            check("ds_aw_rdy", ds_aw_rdy_o, exp_aw_rdy);
            check("ds_w_rdy", ds_w_rdy_o, exp_w_rdy);
            check("wvalid", m_wvalid_o, exp_wvalid);
            check("bready", m_bready_o, run_m);
            check("frame_done", frame_done_o, exp_fd);
            check("wr_err", wr_err_o, exp_err);
            if (exp_awv) check("awaddr", m_awaddr_o, 64'((aw_n % BPF) * BURST_BYTES));
            if (exp_wvalid && word_q.size() > 0) begin
                check("wdata", m_wdata_o, word_q[0]);
                check("wlast", m_wlast_o, (pop_n % 2) == 1);
                check("wstrb", m_wstrb_o, 4'hF);
            end
            if (frame_done_o === 1'b1) fd_count++;
        end
        if (rst) begin
            started = 1; run_m = 0;
            aw_n = 0; b_n = 0; pix_n = 0; pop_n = 0;
            part.delete(); word_q.delete();
            exp_awv = 0; exp_aw_rdy = 0; exp_w_rdy = 0; exp_wvalid = 0; exp_fd = 0; exp_err = 0;
            pxl_taken = 0;
        end else if (started) begin
            aw_h = exp_awv & m_awready_i;
            w_h  = exp_wvalid & m_wready_i;
            b_h  = m_bvalid_i & run_m;
            p_h  = ds_pxl_vld_i & exp_aw_rdy & exp_w_rdy;
            if (aw_h) aw_log.push_back(m_awaddr_o);
            if (w_h) begin
                w_log.push_back(m_wdata_o);
                wl_log.push_back(m_wlast_o);
            end
            outstd_before = aw_n - b_n;
            n_awv  = exp_awv ? !aw_h : (outstd_before < 2);
            exp_fd = b_h && ((b_n % BPF) == BPF - 1);
            if (b_h && m_bresp_i != 2'b00) exp_err = 1;
            aw_n += int'(aw_h);
            b_n  += int'(b_h);
            if (w_h && word_q.size() > 0) begin
                void'(word_q.pop_front());
                pop_n++;
            end
            if (p_h) begin
                part.push_back(ds_pxl_i);
                pix_n++;
                if (part.size() == 4) begin
                    word_q.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                end
            end
            exp_awv    = n_awv;
            exp_aw_rdy = (aw_n - pix_n / PIX_PER_BURST) != 0;
            exp_wvalid = word_q.size() > 0;
            exp_w_rdy  = word_q.size() < 2;
            run_m      = 1;
            pxl_taken  = p_h;
        end
    end

    // Upstream pixel source and AXI slave
    always @(posedge clk) begin
        #2;
        if (pxl_taken) begin
            next_pix   = next_pix + 8'd1;
            pix_budget = pix_budget - 1;
        end
        m_awready_i = int'($urandom_range(99)) < awr_pct;
        m_wready_i  = int'($urandom_range(99)) < wr_pct;
        if (rst) begin
            ds_pxl_vld_i = 1'b0;
            m_bvalid_i   = 1'b0;
        end else begin
            ds_pxl_vld_i = (pix_budget > 0) && (int'($urandom_range(99)) < vld_pct);
            ds_pxl_i     = next_pix;
            m_bvalid_i   = run_m && (pop_n / 2 - b_n > 0) && (int'($urandom_range(99)) < b_pct);
            m_bresp_i    = (b_n == err_b_idx) ? 2'b10 : 2'b00;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        pix_budget = 0;
        tick(cycles);
        aw_log.delete(); w_log.delete(); wl_log.delete();
        fd_count = 0;
        rst = 1'b0;
    endtask

    task automatic wait_pix(input int target, input int max_cyc, input string name);
        int c = 0;
        while (pix_n < target && c < max_cyc) begin tick(1); c++; end
        check(name, pix_n >= target, 1'b1);
    endtask

    task automatic wait_b(input int target, input int max_cyc, input string name);
        int c = 0;
        while (b_n < target && c < max_cyc) begin tick(1); c++; end
        check(name, b_n >= target, 1'b1);
    endtask

    initial begin
        // Reset / idle: AW stalls at two outstanding with no B returned
        vld_pct = 0; awr_pct = 100; wr_pct = 100; b_pct = 0;
        tick(1);
        check("rst_awvalid", m_awvalid_o, 1'b0);
        check("rst_awaddr", m_awaddr_o, 32'h0);
        check("rst_wdata", m_wdata_o, 32'h0);
        check("rst_awlen", m_awlen_o, 8'd1);
        check("rst_awsize", m_awsize_o, 3'd2);
        check("rst_awburst", m_awburst_o, 2'b01);
        do_reset(3);
        tick(1);
        check("first_awvalid", m_awvalid_o, 1'b1);
        check("first_awaddr", m_awaddr_o, 32'h0);
        tick(10);
        check("idle_aw_count", aw_log.size(), 2);
        if (aw_log.size() >= 2) check("idle_addr1", aw_log[1], 32'h08);
        check("idle_awvalid", m_awvalid_o, 1'b0);
        check("idle_aw_rdy", ds_aw_rdy_o, 1'b1);

        // Packing: pixels 0x01..0x08
        b_pct = 100; vld_pct = 100; next_pix = 8'h01; pix_budget = 8;
        wait_pix(8, 50, "pack_wait");
        tick(5);
        check("pack_beats", w_log.size(), 2);
        if (w_log.size() >= 2) begin
            check("pack_beat0", w_log[0], 32'h04030201);
            check("pack_beat1", w_log[1], 32'h08070605);
            check("pack_wlast0", wl_log[0], 1'b0);
            check("pack_wlast1", wl_log[1], 1'b1);
        end

        // W backpressure: two beats buffered, packer then stops accepting
        wr_pct = 0; vld_pct = 100; awr_pct = 100; b_pct = 100;
        do_reset(2);
        next_pix = 8'($urandom); pix_budget = 32;
        tick(20);
        check("bp_accepted", pix_n, 8);
        check("bp_w_rdy", ds_w_rdy_o, 1'b0);
        check("bp_wvalid", m_wvalid_o, 1'b1);
        wr_pct = 100;
        wait_b(4, 300, "bp_drain");
        tick(3);
        check("bp_beats", w_log.size(), 8);
        check("bp_frame_done", fd_count, 1);

        // AW starvation then release and wrap
        awr_pct = 0;
        do_reset(2);
        pix_budget = 40;
        tick(20);
        check("starve_accepted", pix_n, 0);
        check("starve_aw_rdy", ds_aw_rdy_o, 1'b0);
        awr_pct = 100;
        wait_b(5, 400, "starve_drain");
        if (aw_log.size() >= 5) begin
            check("wrap_addr0", aw_log[0], 32'h00);
            check("wrap_addr1", aw_log[1], 32'h08);
            check("wrap_addr2", aw_log[2], 32'h10);
            check("wrap_addr3", aw_log[3], 32'h18);
            check("wrap_addr4", aw_log[4], 32'h00);
        end else check("wrap_aw_count", aw_log.size() >= 5, 1'b1);

        // Frame with the third B an error, random handshakes
        awr_pct = 70; wr_pct = 60; vld_pct = 80; b_pct = 50;
        do_reset(2);
        err_b_idx = 2; pix_budget = 32;
        wait_b(4, 1000, "frame_wait");
        tick(3);
        check("frame_wr_err", wr_err_o, 1'b1);
        check("frame_done_pulses", fd_count, 1);
        err_b_idx = -1;

        // Mid-burst reset discards the partial burst
        awr_pct = 100; wr_pct = 100; vld_pct = 100; b_pct = 100;
        do_reset(2);
        pix_budget = 5;
        wait_pix(5, 50, "mid_wait");
        rst = 1'b1;
        tick(1);
        check("mid_awvalid", m_awvalid_o, 1'b0);
        check("mid_wvalid", m_wvalid_o, 1'b0);
        check("mid_w_rdy", ds_w_rdy_o, 1'b0);
        check("mid_aw_rdy", ds_aw_rdy_o, 1'b0);
        do_reset(1);
        next_pix = 8'h40; pix_budget = 8;
        wait_pix(8, 50, "mid_refill");
        tick(4);
        if (aw_log.size() > 0) check("mid_first_aw", aw_log[0], 32'h0);
        if (w_log.size() > 0) check("mid_first_beat", w_log[0], 32'h43424140);
        else check("mid_beat_seen", w_log.size() > 0, 1'b1);

        // Randomised multi-frame run
        do_reset(2);
        pix_budget = 6 * BPF * PIX_PER_BURST;
        for (int seg = 0; seg < 60 && b_n < 6 * BPF; seg++) begin
            vld_pct = 25 + int'($urandom_range(75));
            awr_pct = 25 + int'($urandom_range(75));
            wr_pct  = 25 + int'($urandom_range(75));
            b_pct   = 25 + int'($urandom_range(75));
            tick(200);
        end
        tick(3);
        check("rand_b_count", b_n, 6 * BPF);
        check("rand_frames", fd_count, 6);
        check("rand_no_err", wr_err_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
